// File: rtl/as6501_lvds_tx.sv
// AS6501 LVDS result-output emulator: buffers {refid, tstop} words from AXI-Stream and shifts them out MSB-first.
// Define AS6501_TX_WORDCNT_EN to implement the transmitted-word counter on word_cnt_o (otherwise tied to zero).
module as6501_lvds_tx #(
    parameter int REFID_W = 24,
    parameter int TSTOP_W = 20,
    parameter int FRAME_W = 8,
    parameter int GAP_CYC = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       lclk_i,
    input  logic                       lrst_i,
    input  logic                       enable_i,
    input  logic [REFID_W+TSTOP_W-1:0] s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    output logic                       frame_o,
    output logic                       sdo_o,
    output logic                       linterrupt_o,
    output logic                       busy_o,
    output logic [31:0]                word_cnt_o,
    output logic [1:0]                 dbg_state_o
);
    // Handshake: a word is accepted on every lclk_i rising edge where s_axis_tvalid and
    // s_axis_tready are both high; tdata must be stable while tvalid is high and tready is low.

    localparam int W  = REFID_W + TSTOP_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(W + GAP_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [W-1:0]  shreg;
    logic [NW-1:0] cnt;
    logic          push;
    logic          pop;

    assign push = s_axis_tvalid & s_axis_tready;
    // The pop decision uses the registered count, so a word is never popped on its push edge.
    assign pop  = (state == S_IDLE) & enable_i & (count != '0);

    always_comb begin
        count_next = count + CW'(push) - CW'(pop);
    end

    always_ff @(posedge lclk_i) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            s_axis_tready <= 1'b0;
            linterrupt_o  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            // Looking at the next count keeps the registered ready from ever overfilling.
            s_axis_tready <= enable_i & (count_next != CW'(DEPTH));
            linterrupt_o  <= (count == '0);
        end
    end

    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            state   <= S_IDLE;
            shreg   <= '0;
            cnt     <= '0;
            frame_o <= 1'b0;
            sdo_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    frame_o <= 1'b0;
                    sdo_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    if (pop) begin
                        shreg <= mem[rd_ptr];
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sdo_o   <= shreg[W-1];
                    shreg   <= {shreg[W-2:0], 1'b0};
                    frame_o <= (cnt < NW'(FRAME_W));
                    busy_o  <= 1'b1;
                    if (cnt == NW'(W - 1)) begin
                        cnt   <= '0;
                        state <= S_GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    frame_o <= 1'b0;
                    sdo_o   <= 1'b0;
                    busy_o  <= 1'b1;
                    if (cnt == NW'(GAP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    frame_o <= 1'b0;
                    sdo_o   <= 1'b0;
                    busy_o  <= 1'b0;
                    cnt     <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign dbg_state_o = state;

`ifdef AS6501_TX_WORDCNT_EN
    logic [31:0] wcnt;

    // Counts on the edge that drives bit 0, so the new value appears with the last bit.
    always_ff @(posedge lclk_i or posedge lrst_i) begin
        if (lrst_i) begin
            wcnt <= 32'd0;
        end else if ((state == S_SHIFT) && (cnt == NW'(W - 1))) begin
            wcnt <= wcnt + 32'd1;
        end
    end

    assign word_cnt_o = wcnt;
`else
    assign word_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_as6501_lvds_tx.sv
// Bench for as6501_lvds_tx: a serial monitor deframes frame/sdo into words, tests compare them to the pushed-word queue.
module tb_as6501_lvds_tx;
    localparam int REFID_W = 24;
    localparam int TSTOP_W = 20;
    localparam int FRAME_W = 8;
    localparam int GAP_CYC = 4;
    localparam int DEPTH   = 8;
    localparam int W       = REFID_W + TSTOP_W;
    localparam int PERIOD  = W + GAP_CYC + 1;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         tvalid;
    logic [W-1:0] tdata;
    logic         tready;
    logic         frame;
    logic         sdo;
    logic         lint;
    logic         busy;
    logic [31:0]  wcnt;
    logic [1:0]   dbg_state;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rx_rd = 0;
    int tx_total = 0;
    int last_push_cyc = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_data_q[$];
    int           rx_flen_q[$];
    int           rx_start_q[$];

    logic         cap_on = 1'b0;
    logic         frame_prev = 1'b0;
    logic [W-1:0] cap_word = '0;
    int           cap_idx = 0;
    int           cap_flen = 0;
    int           cap_start = 0;
    int           stray_cnt = 0;

    as6501_lvds_tx #(
        .REFID_W(REFID_W), .TSTOP_W(TSTOP_W), .FRAME_W(FRAME_W),
        .GAP_CYC(GAP_CYC), .DEPTH(DEPTH)
    ) dut (
        .lclk_i(clk), .lrst_i(rst), .enable_i(enable),
        .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
        .frame_o(frame), .sdo_o(sdo), .linterrupt_o(lint), .busy_o(busy),
        .word_cnt_o(wcnt), .dbg_state_o(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver side: a frame rising edge starts a W-bit capture sampled mid-cycle.
    always @(negedge clk) begin
        frame_prev <= frame;
        if (rst) begin
            cap_on <= 1'b0;
        end else if (cap_on) begin
            cap_word <= {cap_word[W-2:0], sdo};
            cap_flen <= cap_flen + (frame ? 1 : 0);
            cap_idx  <= cap_idx + 1;
            if (cap_idx == W - 1) begin
                rx_data_q.push_back({cap_word[W-2:0], sdo});
                rx_flen_q.push_back(cap_flen + (frame ? 1 : 0));
                rx_start_q.push_back(cap_start);
                cap_on <= 1'b0;
            end
        end else if (frame && !frame_prev) begin
            cap_on    <= 1'b1;
            cap_word  <= {{(W-1){1'b0}}, sdo};
            cap_idx   <= 1;
            cap_flen  <= 1;
            cap_start <= cyc;
        end else if (sdo) begin
            stray_cnt <= stray_cnt + 1;
        end
    end

    function automatic logic [W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic logic [W-1:0] pop_exp();
        if (exp_q.size() == 0) return '0;
        return exp_q.pop_front();
    endfunction

    function automatic logic [31:0] exp_wcnt();
`ifdef AS6501_TX_WORDCNT_EN
        return 32'(tx_total);
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_word(input logic [W-1:0] d, output int waited);
        int t;
        t = 0;
        tdata  = d;
        tvalid = 1'b1;
        while (tready !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (tready !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL push_timeout tready=%b after %0d cycles, need 1", tready, t);
        end else begin
            exp_q.push_back(d);
            @(negedge clk);
            last_push_cyc = cyc;
        end
        tvalid = 1'b0;
        waited = t;
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        int t;
        t = 0;
        while ((rx_data_q.size() - rx_rd) < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = ((rx_data_q.size() - rx_rd) >= n);
    endtask

    task automatic get_rx(output logic [W-1:0] d, output int flen, output int start, output bit ok);
        if (rx_rd < rx_data_q.size()) begin
            d     = rx_data_q[rx_rd];
            flen  = rx_flen_q[rx_rd];
            start = rx_start_q[rx_rd];
            rx_rd++;
            tx_total++;
            ok = 1'b1;
        end else begin
            d = '0; flen = 0; start = 0; ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; tvalid = 1'b0; tdata = '0;
        idle(3);
        vectors++; if (tready !== 1'b0) begin miscompares++; $display("FAIL rst_tready got=%b exp=0", tready); end
        vectors++; if (frame !== 1'b0) begin miscompares++; $display("FAIL rst_frame got=%b exp=0", frame); end
        vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL rst_sdo got=%b exp=0", sdo); end
        vectors++; if (lint !== 1'b1) begin miscompares++; $display("FAIL rst_lint got=%b exp=1", lint); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", busy); end
        vectors++; if (wcnt !== 32'd0) begin miscompares++; $display("FAIL rst_wcnt got=%0d exp=0", wcnt); end
        rst = 1'b0;
        idle(1);
        vectors++; if (tready !== 1'b1) begin miscompares++; $display("FAIL rst_tready_rise got=%b exp=1", tready); end
    endtask

    task automatic test_single_word();
        logic [W-1:0] exp, got;
        int waited, pc, lint_low, busy_hi, flen, st;
        bit ok;
        idle(5);
        push_word({24'h000003, 20'h00E04}, waited);
        pc = last_push_cyc;
        lint_low = 0; busy_hi = 0;
        repeat (80) begin
            if (lint === 1'b0) lint_low++;
            if (busy === 1'b1) busy_hi++;
            @(negedge clk);
        end
        get_rx(got, flen, st, ok);
        exp = pop_exp();
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL single_data got=%h exp=%h", got, exp); end
        vectors++; if (flen != FRAME_W) begin miscompares++; $display("FAIL single_frame_len got=%0d exp=%0d", flen, FRAME_W); end
        vectors++; if (st != pc + 2) begin miscompares++; $display("FAIL single_latency got=%0d exp=%0d", st - pc, 2); end
        vectors++; if (lint_low != 1) begin miscompares++; $display("FAIL single_lint_low got=%0d exp=1", lint_low); end
        vectors++; if (busy_hi != W + GAP_CYC) begin miscompares++; $display("FAIL single_busy got=%0d exp=%0d", busy_hi, W + GAP_CYC); end
        vectors++; if (wcnt !== exp_wcnt()) begin miscompares++; $display("FAIL single_wcnt got=%0d exp=%0d", wcnt, exp_wcnt()); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp, got;
        int waited, busy_lo, flen;
        int st[3];
        bit ok;
        idle(10);
        for (int i = 0; i < 3; i++) push_word(rand_word(), waited);
        busy_lo = 0;
        repeat (3 * PERIOD - GAP_CYC - 1) begin
            if (busy !== 1'b1) busy_lo++;
            @(negedge clk);
        end
        wait_rx(3, 4 * PERIOD, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout got=%0d words exp=3", rx_data_q.size() - rx_rd); end
        for (int i = 0; i < 3; i++) begin
            get_rx(got, flen, st[i], ok);
            exp = pop_exp();
            vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL b2b_data%0d got=%h exp=%h", i, got, exp); end
            vectors++; if (flen != FRAME_W) begin miscompares++; $display("FAIL b2b_frame_len%0d got=%0d exp=%0d", i, flen, FRAME_W); end
        end
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (st[i+1] - st[i] != PERIOD) begin
                miscompares++; $display("FAIL b2b_period%0d got=%0d exp=%0d", i, st[i+1] - st[i], PERIOD);
            end
        end
        vectors++; if (busy_lo != 2) begin miscompares++; $display("FAIL b2b_busy_low got=%0d exp=2", busy_lo); end
    endtask

    task automatic test_full_fifo();
        logic [W-1:0] exp, got;
        int waited, first_stall, flen, st;
        bit ok;
        idle(10);
        first_stall = -1;
        for (int i = 0; i < 12; i++) begin
            push_word(rand_word(), waited);
            if (waited > 0 && first_stall < 0) first_stall = i;
        end
        vectors++; if (first_stall != DEPTH + 1) begin miscompares++; $display("FAIL full_stall_at got=%0d exp=%0d", first_stall, DEPTH + 1); end
        wait_rx(12, 13 * PERIOD, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL full_timeout got=%0d words exp=12", rx_data_q.size() - rx_rd); end
        for (int i = 0; i < 12; i++) begin
            get_rx(got, flen, st, ok);
            exp = pop_exp();
            vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL full_data%0d got=%h exp=%h", i, got, exp); end
        end
        idle(GAP_CYC + 2);
        vectors++; if (wcnt !== exp_wcnt()) begin miscompares++; $display("FAIL full_wcnt got=%0d exp=%0d", wcnt, exp_wcnt()); end
    endtask

    task automatic test_enable_drop();
        logic [W-1:0] exp, got;
        int waited, lint_hi, rx0, flen, st;
        bit ok;
        idle(10);
        for (int i = 0; i < 3; i++) push_word(rand_word(), waited);
        idle(10);
        enable = 1'b0;
        rx0 = rx_data_q.size();
        lint_hi = 0;
        repeat (3 * PERIOD) begin
            if (lint !== 1'b0) lint_hi++;
            @(negedge clk);
        end
        vectors++; if (rx_data_q.size() - rx0 != 1) begin miscompares++; $display("FAIL endrop_words got=%0d exp=1", rx_data_q.size() - rx0); end
        vectors++; if (lint_hi != 0) begin miscompares++; $display("FAIL endrop_lint_high got=%0d exp=0", lint_hi); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL endrop_busy got=%b exp=0", busy); end
        vectors++; if (tready !== 1'b0) begin miscompares++; $display("FAIL endrop_tready got=%b exp=0", tready); end
        get_rx(got, flen, st, ok);
        exp = pop_exp();
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL endrop_data0 got=%h exp=%h", got, exp); end
        enable = 1'b1;
        wait_rx(2, 3 * PERIOD, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL endrop_resume_timeout got=%0d words exp=2", rx_data_q.size() - rx_rd); end
        for (int i = 1; i < 3; i++) begin
            get_rx(got, flen, st, ok);
            exp = pop_exp();
            vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL endrop_data%0d got=%h exp=%h", i, got, exp); end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [W-1:0] d0, exp, got;
        int waited, rx0, pc, flen, st;
        bit ok;
        idle(10);
        d0 = rand_word();
        d0[W-1-20] = 1'b1;
        push_word(d0, waited);
        push_word(rand_word(), waited);
        idle(1 + 20);
        vectors++; if (sdo !== 1'b1) begin miscompares++; $display("FAIL rmw_bit20 got=%b exp=1", sdo); end
        rst = 1'b1;
        #1;
        vectors++; if (frame !== 1'b0) begin miscompares++; $display("FAIL rmw_frame got=%b exp=0", frame); end
        vectors++; if (sdo !== 1'b0) begin miscompares++; $display("FAIL rmw_sdo got=%b exp=0", sdo); end
        vectors++; if (lint !== 1'b1) begin miscompares++; $display("FAIL rmw_lint got=%b exp=1", lint); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rmw_busy got=%b exp=0", busy); end
        vectors++; if (tready !== 1'b0) begin miscompares++; $display("FAIL rmw_tready got=%b exp=0", tready); end
        exp_q.delete();
        tx_total = 0;
        @(negedge clk);
        rst = 1'b0;
        rx0 = rx_data_q.size();
        idle(3 * PERIOD);
        vectors++; if (rx_data_q.size() != rx0) begin miscompares++; $display("FAIL rmw_retransmit got=%0d words exp=0", rx_data_q.size() - rx0); end
        vectors++; if (lint !== 1'b1) begin miscompares++; $display("FAIL rmw_fifo_empty lint=%b exp=1", lint); end
        vectors++; if (wcnt !== exp_wcnt()) begin miscompares++; $display("FAIL rmw_wcnt got=%0d exp=%0d", wcnt, exp_wcnt()); end
        push_word(rand_word(), waited);
        pc = last_push_cyc;
        wait_rx(1, 2 * PERIOD, ok);
        get_rx(got, flen, st, ok);
        exp = pop_exp();
        vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL rmw_after_data got=%h exp=%h", got, exp); end
        vectors++; if (st != pc + 2) begin miscompares++; $display("FAIL rmw_after_latency got=%0d exp=2", st - pc); end
    endtask

    task automatic test_loopback_random();
        logic [W-1:0] exp, got;
        int waited, flen, st;
        bit ok;
        idle(10);
        for (int i = 0; i < 16; i++) begin
            push_word(rand_word(), waited);
            idle($urandom_range(0, 3));
        end
        wait_rx(16, 17 * PERIOD, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL loop_timeout got=%0d words exp=16", rx_data_q.size() - rx_rd); end
        for (int i = 0; i < 16; i++) begin
            get_rx(got, flen, st, ok);
            exp = pop_exp();
            vectors++; if (!ok || got !== exp) begin miscompares++; $display("FAIL loop_data%0d got=%h exp=%h", i, got, exp); end
            vectors++; if (flen != FRAME_W) begin miscompares++; $display("FAIL loop_frame_len%0d got=%0d exp=%0d", i, flen, FRAME_W); end
        end
        idle(GAP_CYC + 2);
        vectors++; if (stray_cnt != 0) begin miscompares++; $display("FAIL loop_stray_sdo got=%0d exp=0", stray_cnt); end
        vectors++; if (wcnt !== exp_wcnt()) begin miscompares++; $display("FAIL loop_wcnt got=%0d exp=%0d", wcnt, exp_wcnt()); end
        vectors++; if (lint !== 1'b1) begin miscompares++; $display("FAIL loop_lint_idle got=%b exp=1", lint); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; tvalid = 1'b0; tdata = '0;
        test_reset();
        test_single_word();
        test_back_to_back();
        test_full_fifo();
        test_enable_drop();
        test_reset_mid_word();
        test_loopback_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
